// File: rtl/htif_pkg.sv
// rtl/htif_pkg.sv - HTIF command layout, device/command codes and responder states
package htif_pkg;

    typedef struct packed {
        logic [7:0]  dev;
        logic [7:0]  cmd;
        logic [47:0] payload;
    } htif_cmd_t;

    localparam logic [7:0] HTIF_DEV_SYSCALL = 8'd0;
    localparam logic [7:0] HTIF_DEV_CONSOLE = 8'd1;
    localparam logic [7:0] HTIF_CMD_PUTCHAR = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_HALT
    } htif_state_e;

    // Syscall device with bit 0 set is the test-exit request.
    function automatic logic htif_is_exit(htif_cmd_t t);
        return (t.dev == HTIF_DEV_SYSCALL) && t.payload[0];
    endfunction

    function automatic logic htif_is_putchar(htif_cmd_t t);
        return (t.dev == HTIF_DEV_CONSOLE) && (t.cmd == HTIF_CMD_PUTCHAR);
    endfunction

endpackage

// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - RVFI commit record (fields consumed by the HTIF responder)
package rvfi_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] mem_addr;
        logic [7:0]  mem_wmask;
        logic [63:0] mem_wdata;
    } rvfi_instr_t;

endpackage

// File: rtl/htif_cmd_fifo.sv
// rtl/htif_cmd_fifo.sv - multi-push, single-pop FIFO of pending HTIF commands
import htif_pkg::*;

module htif_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + NPUSH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NPUSH-1:0]      push_valid_i,
    input  htif_cmd_t [NPUSH-1:0] push_data_i,
    input  logic                  pop_i,
    output htif_cmd_t             head_o,
    output logic                  empty_o,
    output logic [CNT_W-1:0]      push_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    htif_cmd_t        mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;

    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] n_acc;
    logic [NPUSH-1:0] wr_en;
    logic [PW-1:0]    wr_idx [NPUSH];
    logic             pop_eff;

    // Accept requesters in index order into consecutive slots until the free space runs out.
    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
        n_acc      = '0;
        wr_en      = '0;
        for (int i = 0; i < int'(NPUSH); i++) begin
            wr_idx[i] = '0;
            if (push_valid_i[i] && (n_acc < free_slots)) begin
                wr_en[i]  = 1'b1;
                wr_idx[i] = wptr_q + n_acc[PW-1:0];
                n_acc     = n_acc + CNT_W'(1);
            end
        end
    end

    assign pop_eff    = pop_i && (count_q != '0);
    assign head_o     = mem_q[rptr_q];
    assign empty_o    = (count_q == '0);
    assign push_cnt_o = n_acc;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NPUSH); i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= push_data_i[i];
            end
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count moves by pushes minus pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + n_acc[PW-1:0];
            rptr_q  <= rptr_q + PW'(pop_eff);
            count_q <= count_q + n_acc - CNT_W'(pop_eff);
        end
    end

endmodule

// File: rtl/htif_responder.sv
// rtl/htif_responder.sv - captures tohost stores from RVFI and executes HTIF commands
import htif_pkg::*;

module htif_responder #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [63:0] TOHOST_ADDR     = 64'h8000_1000,
    parameter logic [63:0] FROMHOST_ADDR   = 64'h8000_1008
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output logic                                      wr_req_o,
    output logic [63:0]                               wr_addr_o,
    output logic [63:0]                               wr_data_o,
    input  logic                                      wr_gnt_i,
    output logic                                      putchar_valid_o,
    output logic [7:0]                                putchar_o,
    output logic                                      exit_valid_o,
    output logic [63:0]                               exit_code_o,
    output logic                                      cmd_err_o,
    output logic                                      overflow_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + NR_COMMIT_PORTS + 1);

    htif_state_e                     state_q;
    logic [NR_COMMIT_PORTS-1:0]      qual;
    htif_cmd_t [NR_COMMIT_PORTS-1:0] push_data;
    logic [CNT_W-1:0]                qual_cnt;
    logic [CNT_W-1:0]                push_cnt;
    htif_cmd_t                       head;
    logic                            fifo_empty;
    logic                            pop;

    logic        wr_req_q, putchar_valid_q, exit_valid_q, cmd_err_q, overflow_q;
    logic [63:0] wr_addr_q, wr_data_q, exit_code_q;
    logic [7:0]  putchar_q;

    // Qualify non-zero stores to tohost on every port; capture stops once halted.
    always_comb begin
        qual      = '0;
        push_data = '0;
        qual_cnt  = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            qual[i] = rvfi_i[i].valid
                   && (rvfi_i[i].mem_wmask != '0)
                   && (rvfi_i[i].mem_addr == TOHOST_ADDR)
                   && (rvfi_i[i].mem_wdata != '0)
                   && (state_q != ST_HALT);
            push_data[i] = htif_cmd_t'(rvfi_i[i].mem_wdata);
            qual_cnt     = qual_cnt + CNT_W'(qual[i]);
        end
    end

    assign pop = (state_q == ST_IDLE) && !fifo_empty;

    htif_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .NPUSH (NR_COMMIT_PORTS),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_valid_i (qual),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .push_cnt_o   (push_cnt)
    );

    // Sticky drop flag: any qualifying store the FIFO could not take.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (qual_cnt != push_cnt) begin
            overflow_q <= 1'b1;
        end
    end

    // Command FSM: pop and decode in IDLE, hold the fromhost write in ACK, stop in HALT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            wr_req_q        <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            putchar_valid_q <= 1'b0;
            putchar_q       <= '0;
            exit_valid_q    <= 1'b0;
            exit_code_q     <= '0;
            cmd_err_q       <= 1'b0;
        end else begin
            putchar_valid_q <= 1'b0;
            cmd_err_q       <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        if (htif_is_exit(head)) begin
                            exit_valid_q <= 1'b1;
                            exit_code_q  <= {1'b0, head[63:1]};
                            state_q      <= ST_HALT;
                        end else begin
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= FROMHOST_ADDR;
                            state_q   <= ST_ACK;
                            if (htif_is_putchar(head)) begin
                                putchar_valid_q <= 1'b1;
                                putchar_q       <= head.payload[7:0];
                                wr_data_q       <= {head.dev, head.cmd, 48'h1};
                            end else begin
                                cmd_err_q <= 1'b1;
                                wr_data_q <= {head.dev, head.cmd, 48'h0};
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (wr_gnt_i) begin
                        wr_req_q  <= 1'b0;
                        wr_addr_q <= '0;
                        wr_data_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_req_o        = wr_req_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_o       = wr_data_q;
    assign putchar_valid_o = putchar_valid_q;
    assign putchar_o       = putchar_q;
    assign exit_valid_o    = exit_valid_q;
    assign exit_code_o     = exit_code_q;
    assign cmd_err_o       = cmd_err_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_htif_responder.sv
// tb/tb_htif_responder.sv - self-checking bench for htif_responder
module tb_htif_responder;
    import rvfi_pkg::*;

    localparam logic [63:0] TOHOST   = 64'h8000_1000;
    localparam logic [63:0] FROMHOST = 64'h8000_1008;

    logic              clk_i  = 1'b0;
    logic              rst_ni = 1'b0;
    logic              wr_gnt_i = 1'b0;
    rvfi_instr_t [1:0] rvfi;
    logic              wr_req_o;
    logic [63:0]       wr_addr_o, wr_data_o, exit_code_o;
    logic              putchar_valid_o, exit_valid_o, cmd_err_o, overflow_o;
    logic [7:0]        putchar_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  q_char [$];
    logic [63:0] q_ack  [$];
    int          q_err   = 0;
    int          n_chars = 0;
    bit          req_prev = 1'b0;

    typedef struct {
        int          port;
        bit          valid;
        logic [63:0] addr;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        int          kind;   // 0 no capture, 1 putchar, 2 unsupported
        logic [7:0]  ch;
        logic [63:0] ack;
    } vec_t;
    vec_t vecs [9];

    htif_responder dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rvfi_i          (rvfi),
        .wr_req_o        (wr_req_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .wr_gnt_i        (wr_gnt_i),
        .putchar_valid_o (putchar_valid_o),
        .putchar_o       (putchar_o),
        .exit_valid_o    (exit_valid_o),
        .exit_code_o     (exit_code_o),
        .cmd_err_o       (cmd_err_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s got=%h exp=none", name, got);
    endfunction

    // Scoreboard side: outputs are sampled on the falling edge and matched against queued expectations.
    always @(negedge clk_i) begin
        if (putchar_valid_o) begin
            n_chars++;
            if (q_char.size() == 0) unexpected("putchar_unexpected", {56'h0, putchar_o});
            else chk("putchar", {56'h0, putchar_o}, {56'h0, q_char.pop_front()});
        end
        if (cmd_err_o) begin
            if (q_err == 0) unexpected("cmd_err_unexpected", 64'h1);
            else begin
                q_err--;
                checks++;
            end
        end
        if (wr_req_o && !req_prev) begin
            if (q_ack.size() == 0) unexpected("ack_unexpected", wr_data_o);
            else chk("ack_data", wr_data_o, q_ack.pop_front());
            chk("ack_addr", wr_addr_o, FROMHOST);
        end
        req_prev = wr_req_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic store(int p, bit v, logic [63:0] addr, logic [7:0] wmask, logic [63:0] data);
        rvfi                = '0;
        rvfi[p].valid       = v;
        rvfi[p].mem_addr    = addr;
        rvfi[p].mem_wmask   = wmask;
        rvfi[p].mem_wdata   = data;
        step();
        rvfi = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        q_char.delete();
        q_ack.delete();
        q_err = 0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    function automatic logic [63:0] pc(logic [7:0] c);
        return {56'h01_01_0000_0000_00, c};
    endfunction

    localparam logic [63:0] PC_ACK = 64'h0101_0000_0000_0001;

    initial begin
        int base;
        vecs[0] = '{0, 1, TOHOST,      8'hff, 64'h0203_0000_0000_0000, 2, 8'h00, 64'h0203_0000_0000_0000};
        vecs[1] = '{0, 1, TOHOST + 8,  8'hff, 64'h0101_0000_0000_0041, 0, 8'h00, 64'h0};
        vecs[2] = '{0, 1, TOHOST,      8'hff, 64'h0,                   0, 8'h00, 64'h0};
        vecs[3] = '{0, 0, TOHOST,      8'hff, 64'h0101_0000_0000_0041, 0, 8'h00, 64'h0};
        vecs[4] = '{1, 1, TOHOST,      8'h00, 64'h0101_0000_0000_0041, 0, 8'h00, 64'h0};
        vecs[5] = '{0, 1, TOHOST,      8'hff, 64'h0101_0000_0000_005a, 1, 8'h5a, PC_ACK};
        vecs[6] = '{0, 1, TOHOST,      8'hff, 64'h0000_0000_0000_0010, 2, 8'h00, 64'h0};
        vecs[7] = '{1, 1, TOHOST,      8'h0f, 64'h0102_0000_0000_0041, 2, 8'h00, 64'h0102_0000_0000_0000};
        vecs[8] = '{1, 1, TOHOST,      8'h01, 64'h0101_0000_0000_0037, 1, 8'h37, PC_ACK};

        rvfi = '0;
        #3;
        chk("rst_wr_req",    {63'h0, wr_req_o},        64'h0);
        chk("rst_wr_addr",   wr_addr_o,                64'h0);
        chk("rst_wr_data",   wr_data_o,                64'h0);
        chk("rst_putchar_v", {63'h0, putchar_valid_o}, 64'h0);
        chk("rst_putchar",   {56'h0, putchar_o},       64'h0);
        chk("rst_exit_v",    {63'h0, exit_valid_o},    64'h0);
        chk("rst_exit_code", exit_code_o,              64'h0);
        chk("rst_cmd_err",   {63'h0, cmd_err_o},       64'h0);
        chk("rst_overflow",  {63'h0, overflow_o},      64'h0);
        do_reset();

        // Single-store vectors with the grant tied high.
        wr_gnt_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].kind == 1) q_char.push_back(vecs[i].ch);
            if (vecs[i].kind == 2) q_err++;
            if (vecs[i].kind != 0) q_ack.push_back(vecs[i].ack);
            store(vecs[i].port, vecs[i].valid, vecs[i].addr, vecs[i].wmask, vecs[i].wdata);
            repeat (6) step();
            chk($sformatf("drain_char_v%0d", i), 64'(q_char.size()), 64'h0);
            chk($sformatf("drain_ack_v%0d", i),  64'(q_ack.size()),  64'h0);
            chk($sformatf("drain_err_v%0d", i),  64'(q_err),         64'h0);
        end

        // Putchar 'A' with grant after three cycles: exact cycle timing of pulse and request.
        wr_gnt_i = 1'b0;
        q_char.push_back(8'h41);
        q_ack.push_back(PC_ACK);
        store(0, 1, TOHOST, 8'hff, 64'h0101_0000_0000_0041);
        chk("a_no_early_pulse", {63'h0, putchar_valid_o}, 64'h0);
        chk("a_no_early_req",   {63'h0, wr_req_o},        64'h0);
        step();
        chk("a_pulse", {63'h0, putchar_valid_o}, 64'h1);
        chk("a_char",  {56'h0, putchar_o},       64'h41);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("a_req_c%0d", c),  {63'h0, wr_req_o}, 64'h1);
            chk($sformatf("a_data_c%0d", c), wr_data_o,         PC_ACK);
            chk($sformatf("a_addr_c%0d", c), wr_addr_o,         FROMHOST);
            if (c == 2) chk("a_pulse_once", {63'h0, putchar_valid_o}, 64'h0);
            if (c == 4) wr_gnt_i = 1'b1;
            step();
        end
        wr_gnt_i = 1'b0;
        chk("a_req_dropped", {63'h0, wr_req_o}, 64'h0);
        step();
        step();

        // Both ports on one edge: 'a' then 'b', two cycles apart.
        wr_gnt_i = 1'b1;
        q_char.push_back(8'h61);
        q_char.push_back(8'h62);
        q_ack.push_back(PC_ACK);
        q_ack.push_back(PC_ACK);
        rvfi = '0;
        rvfi[0].valid = 1'b1; rvfi[0].mem_addr = TOHOST; rvfi[0].mem_wmask = 8'hff; rvfi[0].mem_wdata = pc(8'h61);
        rvfi[1].valid = 1'b1; rvfi[1].mem_addr = TOHOST; rvfi[1].mem_wmask = 8'hff; rvfi[1].mem_wdata = pc(8'h62);
        step();
        rvfi = '0;
        step();
        chk("ab_first_pulse", {63'h0, putchar_valid_o}, 64'h1);
        chk("ab_first_char",  {56'h0, putchar_o},       64'h61);
        step();
        chk("ab_gap",         {63'h0, putchar_valid_o}, 64'h0);
        step();
        chk("ab_second_pulse", {63'h0, putchar_valid_o}, 64'h1);
        chk("ab_second_char",  {56'h0, putchar_o},       64'h62);
        repeat (4) step();
        chk("ab_drain", 64'(q_char.size()), 64'h0);

        // Overflow: one command parks in ACK, then five more stores into a four-slot FIFO.
        wr_gnt_i = 1'b0;
        base = n_chars;
        q_char.push_back(8'h50);
        q_ack.push_back(PC_ACK);
        store(0, 1, TOHOST, 8'hff, pc(8'h50));
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) begin
                q_char.push_back(8'h30 + 8'(i));
                q_ack.push_back(PC_ACK);
            end
            store(0, 1, TOHOST, 8'hff, pc(8'h30 + 8'(i)));
        end
        step();
        chk("ovf_flag",           {63'h0, overflow_o}, 64'h1);
        chk("ovf_stalled_chars",  64'(n_chars - base), 64'h1);
        base = n_chars;
        wr_gnt_i = 1'b1;
        repeat (20) step();
        chk("ovf_released_chars", 64'(n_chars - base), 64'h4);
        chk("ovf_drain",          64'(q_char.size()),  64'h0);
        chk("ovf_sticky",         {63'h0, overflow_o}, 64'h1);

        // Exit with code 0x2A.
        do_reset();
        store(0, 1, TOHOST, 8'hff, 64'h55);
        step();
        chk("exit55_valid", {63'h0, exit_valid_o}, 64'h1);
        chk("exit55_code",  exit_code_o,           64'h2a);
        chk("exit55_noreq", {63'h0, wr_req_o},     64'h0);
        step();
        chk("exit55_sticky", {63'h0, exit_valid_o}, 64'h1);

        // Exit with code 0, then later tohost stores are ignored.
        do_reset();
        chk("reset_clears_exit", {63'h0, exit_valid_o}, 64'h0);
        store(0, 1, TOHOST, 8'hff, 64'h1);
        step();
        chk("exit1_valid", {63'h0, exit_valid_o}, 64'h1);
        chk("exit1_code",  exit_code_o,           64'h0);
        base = n_chars;
        store(0, 1, TOHOST, 8'hff, pc(8'h78));
        store(1, 1, TOHOST, 8'hff, 64'h55);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("halt_noreq_c%0d", c), {63'h0, wr_req_o}, 64'h0);
            step();
        end
        chk("halt_no_chars",  64'(n_chars - base), 64'h0);
        chk("halt_code_kept", exit_code_o,         64'h0);

        // Reset during ACK with a full FIFO and overflow set.
        do_reset();
        wr_gnt_i = 1'b0;
        q_char.push_back(8'h52);
        q_ack.push_back(PC_ACK);
        store(0, 1, TOHOST, 8'hff, pc(8'h52));
        for (int i = 0; i < 5; i++) store(0, 1, TOHOST, 8'hff, pc(8'h40 + 8'(i)));
        chk("rack_req_before", {63'h0, wr_req_o},   64'h1);
        chk("rack_ovf_before", {63'h0, overflow_o}, 64'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rack_req",       {63'h0, wr_req_o},        64'h0);
        chk("rack_addr",      wr_addr_o,                64'h0);
        chk("rack_data",      wr_data_o,                64'h0);
        chk("rack_ovf",       {63'h0, overflow_o},      64'h0);
        chk("rack_exit",      {63'h0, exit_valid_o},    64'h0);
        chk("rack_putchar_v", {63'h0, putchar_valid_o}, 64'h0);
        chk("rack_putchar",   {56'h0, putchar_o},       64'h0);
        q_char.delete();
        q_ack.delete();
        q_err = 0;
        step();
        rst_ni = 1'b1;
        wr_gnt_i = 1'b1;
        base = n_chars;
        repeat (10) step();
        chk("rack_fifo_empty", 64'(n_chars - base), 64'h0);
        chk("rack_req_after",  {63'h0, wr_req_o},   64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
